// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encodings and the default bit period.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    READ  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int DEFAULT_DELAY = 234;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Both flops load RESET_VAL while reset is low.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_reg <= RESET_VAL;
      sync_reg <= RESET_VAL;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 framing, LSB first, DELAY clocks per bit, with one held byte
// and ready/frame-error/overrun status flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DELAY = DEFAULT_DELAY
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxPin,
  input  logic       out_enable,
  input  logic       read_ack,
  output logic [7:0] bus,
  output logic       readyFlag,
  output logic       frameError,
  output logic       overrunFlag
);

  localparam logic [7:0] HALF_LAST = 8'(DELAY / 2 - 1);
  localparam logic [7:0] BIT_LAST  = 8'(DELAY - 1);

  logic        rx_sync;
  logic        rx_prev_reg;
  uart_state_t state_reg, state_next;
  logic [7:0]  count_reg, count_next;
  logic [2:0]  index_reg, index_next;
  logic [7:0]  shift_reg, shift_next;
  logic [7:0]  hold_reg, hold_next;
  logic        ready_reg, ready_next;
  logic        ferr_reg, ferr_next;
  logic        ovr_reg, ovr_next;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rxPin),
    .q     (rx_sync)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_prev_reg <= 1'b1;
      state_reg   <= IDLE;
      count_reg   <= 8'd0;
      index_reg   <= 3'd0;
      shift_reg   <= 8'd0;
      hold_reg    <= 8'd0;
      ready_reg   <= 1'b0;
      ferr_reg    <= 1'b0;
      ovr_reg     <= 1'b0;
    end else begin
      rx_prev_reg <= rx_sync;
      state_reg   <= state_next;
      count_reg   <= count_next;
      index_reg   <= index_next;
      shift_reg   <= shift_next;
      hold_reg    <= hold_next;
      ready_reg   <= ready_next;
      ferr_reg    <= ferr_next;
      ovr_reg     <= ovr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg + 8'd1;
    index_next = index_reg;
    shift_next = shift_reg;
    hold_next  = hold_reg;
    ready_next = ready_reg;
    ferr_next  = ferr_reg;
    ovr_next   = ovr_reg;

    // A good stop below re-sets readyFlag, so an ack landing on it leaves ready=1, overrun=0.
    if (read_ack) begin
      ready_next = 1'b0;
      ovr_next   = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        count_next = 8'd0;
        if (rx_prev_reg && !rx_sync) state_next = START;
      end
      START: begin
        if (count_reg == HALF_LAST) begin
          count_next = 8'd0;
          if (!rx_sync) begin
            index_next = 3'd0;
            state_next = READ;
          end else begin
            state_next = IDLE;
          end
        end
      end
      READ: begin
        if (count_reg == BIT_LAST) begin
          count_next            = 8'd0;
          shift_next[index_reg] = rx_sync;
          index_next            = index_reg + 3'd1;
          if (index_reg == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        if (count_reg == BIT_LAST) begin
          count_next = 8'd0;
          state_next = IDLE;
          if (rx_sync) begin
            hold_next  = shift_reg;
            ready_next = 1'b1;
            ferr_next  = 1'b0;
            if (ready_reg && !read_ack) ovr_next = 1'b1;
          end else begin
            ferr_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        count_next = 8'd0;
      end
    endcase
  end

  assign bus         = out_enable ? hold_reg : 8'bz;
  assign readyFlag   = ready_reg;
  assign frameError  = ferr_reg;
  assign overrunFlag = ovr_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus randomized frames, checked every cycle
// against a frame-level model of the held byte and status flags.
module tb_uart_rx;

  localparam int D = 234;
  localparam int H = D / 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rxPin = 1'b1;
  logic       out_enable = 1'b1;
  logic       read_ack = 1'b0;
  wire  [7:0] bus;
  logic       readyFlag;
  logic       frameError;
  logic       overrunFlag;

  uart_rx #(.DELAY(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .rxPin       (rxPin),
    .out_enable  (out_enable),
    .read_ack    (read_ack),
    .bus         (bus),
    .readyFlag   (readyFlag),
    .frameError  (frameError),
    .overrunFlag (overrunFlag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         t;
    logic [7:0] d;
    bit         good;
  } ev_t;

  ev_t pending[$];

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;
  int last_ev_t = -100;
  int last_done_t = 0;
  int last_fall = 0;
  bit rand_en = 1'b0;

  bit         m_ready = 1'b0;
  bit         m_ferr = 1'b0;
  bit         m_ovr = 1'b0;
  logic [7:0] m_hold = 8'h00;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_tol(input string name, input int act, input int exp, input int tol);
    n_checks++;
    if (act < exp - tol || act > exp + tol) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  // Frame-level model: a byte lands when its stop bit is due; ack clears flags.
  initial begin : compare
    ev_t e;
    bit  have_ev;
    bit  ack;
    bit  near;
    forever begin
      @(posedge clk);
      cyc++;
      have_ev = 1'b0;
      if (pending.size() > 0 && pending[0].t == cyc) begin
        e = pending.pop_front();
        have_ev = 1'b1;
        last_ev_t = cyc;
      end
      if (!reset) begin
        m_ready = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0; m_hold = 8'h00;
      end else begin
        ack = read_ack;
        if (have_ev && e.good) begin
          if (ack) m_ovr = 1'b0;
          else if (m_ready) m_ovr = 1'b1;
          m_ready = 1'b1;
          m_hold  = e.d;
          m_ferr  = 1'b0;
        end else begin
          if (have_ev) m_ferr = 1'b1;
          if (ack) begin
            m_ready = 1'b0;
            m_ovr   = 1'b0;
          end
        end
      end
      #1;
      near = (cyc - last_ev_t <= 1) || (pending.size() > 0 && pending[0].t - cyc <= 1);
      if (!near) begin
        check("cmp_ready", int'(readyFlag), int'(m_ready));
        check("cmp_ferr", int'(frameError), int'(m_ferr));
        check("cmp_ovr", int'(overrunFlag), int'(m_ovr));
        if (out_enable) check("cmp_bus", int'(bus), int'(m_hold));
      end
    end
  end

  // Drives one 8N1 frame; abort_bit >= 0 pulses reset midway through that data bit.
  task automatic send_frame(input logic [7:0] d, input bit good, input int abort_bit);
    ev_t e;
    @(negedge clk);
    rxPin = 1'b0;
    last_fall = cyc + 1;
    e.t = last_fall + 2 + H + 9 * D;
    e.d = d;
    e.good = good;
    last_done_t = e.t;
    pending.push_back(e);
    repeat (D) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxPin = d[i];
      if (i == abort_bit) begin
        repeat (D / 2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("rst_async_ready", int'(readyFlag), 0);
        check("rst_async_ferr", int'(frameError), 0);
        check("rst_async_ovr", int'(overrunFlag), 0);
        check("rst_async_bus", int'(bus), 0);
        pending.delete();
        rxPin = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        return;
      end
      repeat (D) @(negedge clk);
    end
    rxPin = good;
    repeat (D) @(negedge clk);
    rxPin = 1'b1;
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    read_ack = 1'b1;
    @(negedge clk);
    read_ack = 1'b0;
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int rise;
    repeat (2) @(negedge clk);
    check("reset_ready", int'(readyFlag), 0);
    check("reset_ferr", int'(frameError), 0);
    check("reset_ovr", int'(overrunFlag), 0);
    check("reset_bus", int'(bus), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Latency and data for 0xA5.
    rise = -1;
    fork
      send_frame(8'hA5, 1'b1, -1);
      begin
        for (int k = 0; k < 3000 && rise < 0; k++) begin
          @(posedge clk);
          #1;
          if (readyFlag) rise = cyc;
        end
      end
    join
    check_tol("latency_a5", rise - last_fall - 2, 2223, 1);
    check("a5_bus", int'(bus), 8'hA5);
    check("a5_ready", int'(readyFlag), 1);

    // Short low glitch on an idle line.
    @(negedge clk);
    rxPin = 1'b0;
    repeat (50) @(negedge clk);
    rxPin = 1'b1;
    repeat (2 * D) @(negedge clk);
    check("glitch_ready", int'(readyFlag), 1);
    check("glitch_ferr", int'(frameError), 0);
    check("glitch_bus", int'(bus), 8'hA5);

    // Framing error, then recovery.
    ack_pulse();
    check("ack_ready", int'(readyFlag), 0);
    send_frame(8'h3C, 1'b0, -1);
    repeat (D) @(negedge clk);
    check("ferr_set", int'(frameError), 1);
    check("ferr_ready", int'(readyFlag), 0);
    check("ferr_bus", int'(bus), 8'hA5);
    send_frame(8'h11, 1'b1, -1);
    check("rec_ferr", int'(frameError), 0);
    check("rec_ready", int'(readyFlag), 1);
    check("rec_bus", int'(bus), 8'h11);

    // Overrun from back-to-back frames.
    ack_pulse();
    send_frame(8'h01, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    check("ovr_set", int'(overrunFlag), 1);
    check("ovr_bus", int'(bus), 8'hFF);
    ack_pulse();
    check("ovr_ack_ready", int'(readyFlag), 0);
    check("ovr_ack_ovr", int'(overrunFlag), 0);

    // Ack on the very cycle the second byte completes.
    send_frame(8'h22, 1'b1, -1);
    fork
      send_frame(8'h33, 1'b1, -1);
      begin
        @(negedge clk);
        @(negedge clk);
        while (cyc + 1 < last_done_t) @(negedge clk);
        read_ack = 1'b1;
        @(negedge clk);
        read_ack = 0;
      end
    join
    check("coinc_ready", int'(readyFlag), 1);
    check("coinc_ovr", int'(overrunFlag), 0);
    check("coinc_bus", int'(bus), 8'h33);

    // Reset in the middle of bit 4, then a clean frame.
    send_frame(8'h96, 1'b1, 4);
    repeat (D) @(negedge clk);
    check("post_rst_ready", int'(readyFlag), 0);
    send_frame(8'h5A, 1'b1, -1);
    check("post_rst_5a_ready", int'(readyFlag), 1);
    check("post_rst_5a_bus", int'(bus), 8'h5A);
    check("post_rst_5a_ferr", int'(frameError), 0);

    // Randomized frames, stop bits, gaps, acks and bus enables.
    rand_en = 1'b1;
    fork
      begin
        for (int k = 0; k < 12; k++) begin
          send_frame(8'($urandom), ($urandom_range(0, 99) < 85), -1);
          repeat ($urandom_range(0, 300)) @(negedge clk);
        end
        repeat (D) @(negedge clk);
        rand_en = 1'b0;
      end
      begin
        while (rand_en) begin
          @(negedge clk);
          read_ack   = ($urandom_range(0, 150) == 0);
          out_enable = ($urandom_range(0, 3) != 0);
        end
        read_ack   = 1'b0;
        out_enable = 1'b1;
      end
    join
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
